// File: rtl/pe_array_stu_arbiter.sv
// pe_array_stu_arbiter: round-robin packet arbiter merging PE stack-up streams onto one registered upstream bus
module pe_array_stu_arbiter #(
    parameter int NUM_PE = 4,
    parameter int DATA_W = 64,
    parameter int TYPE_W = 2,
    parameter int OOB_W  = 32,
    parameter int CNTL_W = 2
) (
    input  logic                       clk,
    input  logic                       reset_poweron,
    input  logic [NUM_PE-1:0]          pe__stu__valid,
    input  logic [NUM_PE*CNTL_W-1:0]   pe__stu__cntl,
    input  logic [NUM_PE*TYPE_W-1:0]   pe__stu__type,
    input  logic [NUM_PE*DATA_W-1:0]   pe__stu__data,
    input  logic [NUM_PE*OOB_W-1:0]    pe__stu__oob_data,
    output logic [NUM_PE-1:0]          stu__pe__ready,
    output logic                       stu__sys__valid,
    output logic [CNTL_W-1:0]          stu__sys__cntl,
    output logic [TYPE_W-1:0]          stu__sys__type,
    output logic [DATA_W-1:0]          stu__sys__data,
    output logic [OOB_W-1:0]           stu__sys__oob_data,
    input  logic                       sys__stu__ready,
    output logic [$clog2(NUM_PE)-1:0]  stu__sys__peId,
    output logic                       stu__sys__protoErr,
    output logic [15:0]                stu__sys__pktCount
);
    localparam int PW = $clog2(NUM_PE);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   grant, last_grant, pick, idx;
    logic            first_beat, out_valid, accept;
    logic [CNTL_W-1:0] beat_cntl;

    // descending scan so the nearest valid PE after last_grant wins
    always_comb begin
        pick = last_grant;
        idx  = last_grant;
        for (int i = NUM_PE; i >= 1; i--) begin
            idx = PW'((int'(last_grant) + i) % NUM_PE);
            if (pe__stu__valid[idx]) pick = idx;
        end
    end

    assign stu__pe__ready  = (state == XFER && (!out_valid || sys__stu__ready)) ? NUM_PE'(1) << grant : '0;
    assign accept          = |(pe__stu__valid & stu__pe__ready);
    assign beat_cntl       = pe__stu__cntl[grant*CNTL_W +: CNTL_W];
    assign stu__sys__valid = out_valid;

    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = |pe__stu__valid ? XFER : IDLE;
        else if (accept && beat_cntl[1])
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            state              <= IDLE;
            grant              <= '0;
            last_grant         <= PW'(NUM_PE - 1);
            first_beat         <= 1'b0;
            out_valid          <= 1'b0;
            stu__sys__cntl     <= '0;
            stu__sys__type     <= '0;
            stu__sys__data     <= '0;
            stu__sys__oob_data <= '0;
            stu__sys__peId     <= '0;
            stu__sys__protoErr <= 1'b0;
            stu__sys__pktCount <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |pe__stu__valid) begin
                grant      <= pick;
                first_beat <= 1'b1;
            end
            if (accept) begin
                first_beat         <= 1'b0;
                out_valid          <= 1'b1;
                stu__sys__cntl     <= beat_cntl;
                stu__sys__type     <= pe__stu__type[grant*TYPE_W +: TYPE_W];
                stu__sys__data     <= pe__stu__data[grant*DATA_W +: DATA_W];
                stu__sys__oob_data <= pe__stu__oob_data[grant*OOB_W +: OOB_W];
                stu__sys__peId     <= grant;
                // SOM must appear exactly on the first beat of a grant
                if (first_beat != beat_cntl[0]) stu__sys__protoErr <= 1'b1;
                if (beat_cntl[1]) last_grant <= grant;
            end else if (sys__stu__ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && sys__stu__ready && stu__sys__cntl[1])
                stu__sys__pktCount <= stu__sys__pktCount + 16'd1;
        end
    end
endmodule

// File: tb/tb_pe_array_stu_arbiter.sv
// tb_pe_array_stu_arbiter: directed bench for the PE stack-up arbiter
module tb_pe_array_stu_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    pv, pr;
    logic [2*N-1:0]  pc, pt;
    logic [64*N-1:0] pd;
    logic [32*N-1:0] po;
    logic            sv, srdy, perr;
    logic [1:0]      sc, st, pid;
    logic [63:0]     sd;
    logic [31:0]     so;
    logic [15:0]     pcnt;

    pe_array_stu_arbiter dut (
        .clk(clk), .reset_poweron(rst),
        .pe__stu__valid(pv), .pe__stu__cntl(pc), .pe__stu__type(pt),
        .pe__stu__data(pd), .pe__stu__oob_data(po), .stu__pe__ready(pr),
        .stu__sys__valid(sv), .stu__sys__cntl(sc), .stu__sys__type(st),
        .stu__sys__data(sd), .stu__sys__oob_data(so), .sys__stu__ready(srdy),
        .stu__sys__peId(pid), .stu__sys__protoErr(perr), .stu__sys__pktCount(pcnt)
    );

    int checks = 0, failures = 0, cyc = 0, nlog = 0;
    logic [1:0]  src [N][32];
    int          head [N], tail [N];
    bit          infm [N];
    int          lpe [64], lcyc [64];
    logic [1:0]  lcntl [64];
    logic [63:0] ldata [64];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            pv[p]          = infm[p] || head[p] < tail[p];
            pc[2*p +: 2]   = infm[p] ? 2'b11 : src[p][head[p] % 32];
            pt[2*p +: 2]   = 2'(p);
            pd[64*p +: 64] = {32'(p), 32'(head[p])};
            po[32*p +: 32] = 32'(head[p]);
        end
    endtask

    task automatic push(int p, logic [1:0] c);
        src[p][tail[p] % 32] = c;
        tail[p]++;
    endtask

    task automatic clear_src();
        for (int p = 0; p < N; p++) begin
            head[p] = 0;
            tail[p] = 0;
            infm[p] = 1'b0;
        end
    endtask

    // PE sources pop on accept; the output bus is logged on every transfer
    task automatic tick();
        logic [N-1:0] acc;
        logic         otx;
        logic [1:0]   c, id;
        logic [63:0]  d;
        @(negedge clk);
        acc = pv & pr;
        otx = sv & srdy;
        c   = sc;
        d   = sd;
        id  = pid;
        @(posedge clk);
        #1;
        cyc++;
        if (otx) begin
            if (nlog < 64) begin
                lpe[nlog]   = int'(id);
                lcntl[nlog] = c;
                ldata[nlog] = d;
                lcyc[nlog]  = cyc;
            end
            nlog++;
        end
        for (int p = 0; p < N; p++)
            if (acc[p]) begin
                head[p]++;
                if (infm[p]) tail[p]++;
            end
        drive();
    endtask

    task automatic wait_log(int n, int budget, string tag);
        int k = 0;
        while (nlog < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 64'(nlog >= n), 64'd1);
    endtask

    task automatic chk_log(string tag, int i, int pe, logic [1:0] c, int k);
        chk($sformatf("%s_pe%0d", tag, i), 64'(lpe[i]), 64'(pe));
        chk($sformatf("%s_cntl%0d", tag, i), 64'(lcntl[i]), 64'(c));
        chk($sformatf("%s_data%0d", tag, i), ldata[i], {32'(pe), 32'(k)});
    endtask

    initial begin
        int t;
        int         a_pe [6]  = '{1, 1, 1, 3, 3, 3};
        int         a_off [6] = '{3, 4, 5, 7, 8, 9};
        int         a_k [6]   = '{0, 1, 2, 0, 1, 2};
        logic [1:0] a_c [6]   = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10};
        int         b_pe [5]  = '{0, 1, 2, 3, 0};
        logic [1:0] c_c [4]   = '{2'b01, 2'b00, 2'b00, 2'b10};

        srdy = 1'b1;
        clear_src();
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(sv), 0);
        chk("rst_ready", 64'(pr), 0);
        chk("rst_data", sd, 0);
        chk("rst_cntl", 64'(sc), 0);
        chk("rst_peid", 64'(pid), 0);
        chk("rst_perr", 64'(perr), 0);
        chk("rst_pcnt", 64'(pcnt), 0);
        rst = 1'b0;

        // two 3-beat packets from PE1 and PE3
        for (int p = 1; p < 4; p += 2) begin
            push(p, 2'b01);
            push(p, 2'b00);
            push(p, 2'b10);
        end
        drive();
        nlog = 0;
        t = cyc;
        wait_log(6, 30, "a_done");
        for (int i = 0; i < 6; i++) begin
            chk_log("a", i, a_pe[i], a_c[i], a_k[i]);
            chk($sformatf("a_cyc%0d", i), 64'(lcyc[i] - t), 64'(a_off[i]));
        end
        chk("a_pcnt", 64'(pcnt), 2);

        // all PEs streaming single-beat packets
        for (int p = 0; p < N; p++) infm[p] = 1'b1;
        drive();
        nlog = 0;
        t = cyc;
        wait_log(5, 30, "b_done");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("b_pe%0d", i), 64'(lpe[i]), 64'(b_pe[i]));
            chk($sformatf("b_cyc%0d", i), 64'(lcyc[i] - t), 64'(3 + 2 * i));
            chk($sformatf("b_cntl%0d", i), 64'(lcntl[i]), 64'(2'b11));
        end
        clear_src();
        drive();
        tick();
        tick();
        chk("b_hold_ready", 64'(pr), 64'(4'b0010));
        chk("b_hold_valid", 64'(sv), 0);
        chk("b_pcnt", 64'(pcnt), 7);

        // downstream stall mid-packet on PE1
        push(1, 2'b01);
        push(1, 2'b00);
        push(1, 2'b00);
        push(1, 2'b10);
        drive();
        nlog = 0;
        tick();
        chk("c_lat_valid", 64'(sv), 1);
        chk("c_lat_data", sd, {32'd1, 32'd0});
        chk("c_lat_peid", 64'(pid), 1);
        tick();
        srdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("c_stall_valid%0d", i), 64'(sv), 1);
            chk($sformatf("c_stall_data%0d", i), sd, {32'd1, 32'd1});
            chk($sformatf("c_stall_cntl%0d", i), 64'(sc), 0);
            chk($sformatf("c_stall_ready%0d", i), 64'(pr), 0);
        end
        srdy = 1'b1;
        wait_log(4, 20, "c_done");
        for (int i = 0; i < 4; i++) chk_log("c", i, 1, c_c[i], i);
        chk("c_nlog", 64'(nlog), 4);
        chk("c_pcnt", 64'(pcnt), 8);
        chk("c_perr", 64'(perr), 0);

        // PE2 opens a packet without SOM, then sends a clean one
        clear_src();
        push(2, 2'b00);
        push(2, 2'b10);
        push(2, 2'b01);
        push(2, 2'b10);
        drive();
        nlog = 0;
        wait_log(4, 20, "d_done");
        chk_log("d", 0, 2, 2'b00, 0);
        chk_log("d", 3, 2, 2'b10, 3);
        chk("d_perr", 64'(perr), 1);
        chk("d_pcnt", 64'(pcnt), 10);

        // asynchronous reset in the middle of a PE0 packet
        clear_src();
        push(0, 2'b01);
        push(0, 2'b00);
        push(0, 2'b00);
        push(0, 2'b10);
        drive();
        tick();
        tick();
        tick();
        chk("e_pre_valid", 64'(sv), 1);
        chk("e_pre_data", sd, {32'd0, 32'd1});
        rst = 1'b1;
        #1;
        chk("e_rst_valid", 64'(sv), 0);
        chk("e_rst_data", sd, 0);
        chk("e_rst_oob", 64'(so), 0);
        chk("e_rst_type", 64'(st), 0);
        chk("e_rst_ready", 64'(pr), 0);
        chk("e_rst_perr", 64'(perr), 0);
        chk("e_rst_pcnt", 64'(pcnt), 0);
        clear_src();
        push(0, 2'b01);
        push(0, 2'b10);
        push(2, 2'b01);
        push(2, 2'b10);
        drive();
        tick();
        rst = 1'b0;
        nlog = 0;
        wait_log(4, 20, "e_done");
        chk_log("e", 0, 0, 2'b01, 0);
        chk_log("e", 2, 2, 2'b01, 0);
        chk("e_pcnt", 64'(pcnt), 2);

        // packet counter wrap
        rst = 1'b1;
        tick();
        clear_src();
        drive();
        rst = 1'b0;
        infm[0] = 1'b1;
        drive();
        nlog = 0;
        wait_log(65536, 140000, "f_65536");
        chk("f_pcnt_wrap", 64'(pcnt), 0);
        wait_log(65537, 10, "f_65537");
        chk("f_pcnt_one", 64'(pcnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
